axi_lite_master: RTL and testbench

- Single-outstanding AXI4-Lite master. Converts a simple command/response handshake from a local requester (testbench driver or bridge) into AXI4-Lite read and write transactions on the master side of the interconnect.
- Drives the AR/AW/W channels and consumes R/B from the downstream AXI4-Lite slave.
- Returns read data and response codes to the requester.

---
 rtl/axi_lite_master.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite master that turns a cmd/rsp handshake into AR/R or AW/W/B transactions.
// Define AXIL_MASTER_PARALLEL_AW_W_EN to issue AW and W together instead of AW followed by W.
module axi_lite_master #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_RSP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic [15:0]           wr_count_q, wr_count_d;
`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  aw_done_n, w_done_n;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        cmd_ready_d = cmd_ready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_done_n   = aw_done_q | (awvalid_q & awready);
        w_done_n    = w_done_q | (wvalid_q & wready);
`endif
        // Every valid/ready is set on entry to the state that owns it, so outputs stay registered.
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    write_d     = cmd_write;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
`endif
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                    rd_count_d  = rd_count_q + 16'd1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
            S_WADDR: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                aw_done_d = aw_done_n;
                w_done_d  = w_done_n;
                if (aw_done_n && w_done_n) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = S_WRESP;
                end
            end
`else
            S_WADDR: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    state_d   = S_WDATA;
                end
            end
`endif
            S_WDATA: begin
                if (wready) begin
                    wvalid_d = 1'b0;
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    bready_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                    wr_count_d  = wr_count_q + 16'd1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
        // cmd_ready is low during reset and rises on the first clock in IDLE.
        if (state_d == S_IDLE) cmd_ready_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign araddr    = addr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awaddr    = addr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: scoreboard bench for axi_lite_master with a configurable AXI4-Lite slave model.
// Parallel AW/W checks are built when AXIL_MASTER_PARALLEL_AW_W_EN is defined.
module tb_axi_lite_master;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int LAT_RD = 3;
`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
    localparam int LAT_WR = 3;
`else
    localparam int LAT_WR = 4;
`endif

    logic          aclk = 1'b0;
    logic          areset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [15:0]   rd_count, wr_count;

    always #5 aclk = ~aclk;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    int          ar_wait, aw_wait, w_wait;
    logic        r_hold = 1'b0;
    logic [1:0]  r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
    logic [DW-1:0] slv_mem [logic [AW-1:0]];
    logic        aw_got, w_got;
    logic [AW-1:0] aw_lat, wr_a;
    logic [DW-1:0] w_lat, wr_d;

    assign arready = arvalid && (ar_wait >= ar_delay);
    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid  && (w_wait  >= w_delay);

    always @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rvalid <= 1'b0; rdata <= '0; rresp <= '0;
            bvalid <= 1'b0; bresp <= '0;
            aw_got <= 1'b0; w_got <= 1'b0;
            ar_wait <= 0; aw_wait <= 0; w_wait <= 0;
        end else begin
            if (arvalid && arready) begin
                if (!r_hold) begin
                    rvalid <= 1'b1;
                    rdata  <= slv_mem.exists(araddr) ? slv_mem[araddr] : '0;
                    rresp  <= r_resp_cfg;
                end
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready)   ? w_wait + 1  : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_lat <= awaddr; end
            if (wvalid && wready)   begin w_got  <= 1'b1; w_lat  <= wdata;  end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
                wr_a = aw_got ? aw_lat : awaddr;
                wr_d = w_got ? w_lat : wdata;
                slv_mem[wr_a] = wr_d;
                bvalid <= 1'b1;
                bresp  <= b_resp_cfg;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // ---------------- handshake stability monitor ----------------
    logic          pv = 1'b0;
    logic          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr;
    logic [AW-1:0] p_araddr, p_awaddr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic [1:0]    p_resp;
    logic          p_rw;
    int            b_hs = 0;

    always begin
        @(negedge aclk);
        #2;
        if (!areset_n) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                if (p_arv && !p_arr) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
                if (p_awv && !p_awr) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
                if (p_wv && !p_wr)   chk("w_stable", {wvalid, wdata}, {1'b1, p_wdata});
                if (p_rv && !p_rr)   chk("rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
                                         {1'b1, p_rw, p_resp, p_rdata});
            end
            if (bvalid && bready) b_hs++;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv  = wvalid;  p_wr  = wready;  p_wdata  = wdata;
            p_rv  = rsp_valid; p_rr = rsp_ready; p_rdata = rsp_rdata;
            p_resp = rsp_resp; p_rw = rsp_write;
            pv = 1'b1;
        end
    end

    // ---------------- scoreboard and requester ----------------
    typedef struct packed {
        logic          wr;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [15:0]   exp_rd = '0, exp_wr = '0;
    event          hs_ev;

    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int exp_lat, input int hold);
        exp_t e, got;
        int   n, lat;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge aclk);
        -> hs_ev;
        e.wr    = wr;
        e.rdata = wr ? '0 : (ref_mem.exists(addr) ? ref_mem[addr] : '0);
        e.resp  = wr ? b_resp_cfg : r_resp_cfg;
        if (wr) ref_mem[addr] = wd;
        sb.push_back(e);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin @(negedge aclk); lat++; end while (!rsp_valid && lat < 100);
        if (!rsp_valid) begin
            chk("rsp_timeout", 1'b0, 1'b1);
            sb.delete();
            return;
        end
        chk("rsp_latency", lat, exp_lat);
        got = '{wr: rsp_write, rdata: rsp_rdata, resp: rsp_resp};
        e = sb.pop_front();
        chk("rsp_write", got.wr, e.wr);
        chk("rsp_rdata", got.rdata, e.rdata);
        chk("rsp_resp", got.resp, e.resp);
        if (wr) exp_wr++; else exp_rd++;
        chk("rd_count", rd_count, exp_rd);
        chk("wr_count", wr_count, exp_wr);
        for (int h = 0; h < hold; h++) begin
            chk("rsp_hold_vld_rdy", {rsp_valid, cmd_ready}, 2'b10);
            @(negedge aclk);
        end
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1 rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b0;
        logic          rw;
        logic [AW-1:0] ra;
        areset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge aclk);
        #2;
        chk("reset_vld_rdy", {cmd_ready, arvalid, awvalid, wvalid, rready, bready, rsp_valid}, 7'd0);
        chk("reset_regs", {araddr, wdata, rsp_rdata, rsp_resp}, '0);
        chk("reset_counts", {rd_count, wr_count}, 32'd0);
        @(negedge aclk); areset_n = 1'b1;

        // read with zero-wait slave
        slv_mem[12'h010] = 32'hDEADBEEF;
        ref_mem[12'h010] = 32'hDEADBEEF;
        do_cmd(1'b0, 12'h010, '0, LAT_RD, 0);

        // write then read back
        do_cmd(1'b1, 12'h0A5, 32'h12345678, LAT_WR, 0);
        do_cmd(1'b0, 12'h0A5, '0, LAT_RD, 0);

        // AW backpressure and held response
        aw_delay = 5;
        do_cmd(1'b1, 12'h033, 32'hCAFEF00D, LAT_WR + 5, 4);
        aw_delay = 0;

        // error passthrough
        b_resp_cfg = 2'b10;
        do_cmd(1'b1, 12'h044, 32'h00000005, LAT_WR, 0);
        b_resp_cfg = 2'b00;
        r_resp_cfg = 2'b11;
        do_cmd(1'b0, 12'h044, '0, LAT_RD, 1);
        r_resp_cfg = 2'b00;

        // reset while waiting in RDATA
        r_hold = 1'b1;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h0A5;
        while (!cmd_ready) @(negedge aclk);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk("mid_read_rready", rready, 1'b1);
        #3 areset_n = 1'b0;
        #1;
        chk("async_reset_vld", {arvalid, rready, rsp_valid, cmd_ready}, 4'd0);
        chk("async_reset_counts", {rd_count, wr_count}, 32'd0);
        exp_rd = '0; exp_wr = '0;
        sb.delete();
        @(negedge aclk);
        @(negedge aclk);
        #3 areset_n = 1'b1;
        r_hold = 1'b0;
        do_cmd(1'b0, 12'h0A5, '0, LAT_RD, 0);

`ifdef AXIL_MASTER_PARALLEL_AW_W_EN
        // W accepted in cycle 1, AW in cycle 3
        aw_delay = 2;
        b0 = b_hs;
        fork
            do_cmd(1'b1, 12'h0C0, 32'hA5A55A5A, 5, 0);
            begin
                @(hs_ev);
                @(negedge aclk); #2 chk("par_c1_aw_w", {awvalid, wvalid}, 2'b11);
                @(negedge aclk); #2 chk("par_c2_aw_w", {awvalid, wvalid}, 2'b10);
                @(negedge aclk); #2 chk("par_c3_aw_w", {awvalid, wvalid}, 2'b10);
                @(negedge aclk); #2 chk("par_c4_aw_w_b", {awvalid, wvalid, bready}, 3'b001);
            end
        join
        chk("par_b_handshakes", b_hs - b0, 1);
        aw_delay = 0;
`else
        b0 = b_hs;
        do_cmd(1'b1, 12'h0C0, 32'hA5A55A5A, LAT_WR, 0);
        chk("seq_b_handshakes", b_hs - b0, 1);
`endif

        // random mix over a small address window
        for (int i = 0; i < 12; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 12'h100 + 12'(4 * $urandom_range(0, 3));
            r_resp_cfg = 2'($urandom_range(0, 3));
            b_resp_cfg = 2'($urandom_range(0, 3));
            do_cmd(rw, ra, $urandom, rw ? LAT_WR : LAT_RD, $urandom_range(0, 2));
        end

        repeat (3) @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
